// File: rtl/register_file_if.sv
// Bus bundle for the register file: one write port, two read ports,
// plus the valid-tracking status outputs.
interface register_file_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
);
   localparam int AW = $clog2(NREGS);

   logic             EI;
   logic [AW-1:0]    WA;
   logic [WIDTH-1:0] D;
   logic [AW-1:0]    RA;
   logic [AW-1:0]    RB;
   logic [WIDTH-1:0] QA;
   logic [WIDTH-1:0] QB;
   logic             VA;
   logic             VB;
   logic [NREGS-1:0] valid;
   logic [AW:0]      wcount;

   modport master (
      output EI, WA, D, RA, RB,
      input  QA, QB, VA, VB, valid, wcount
   );

   modport slave (
      input  EI, WA, D, RA, RB,
      output QA, QB, VA, VB, valid, wcount
   );
endinterface

// File: rtl/register_file.sv
// NREGS x WIDTH register file: one synchronous write port, two combinational
// read ports with optional write-through, per-register valid bits and a count.
module register_file #(
   parameter int WIDTH   = 8,
   parameter int NREGS   = 4,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input logic             clk,
   input logic             reset,
   register_file_if.slave  bus
);
   localparam int AW = $clog2(NREGS);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [NREGS];
   logic [NREGS-1:0] r_valid;
   logic [AW:0]      r_wcount;

   logic w_hitZero;
   logic w_writeOk;
   logic w_bypassA;
   logic w_bypassB;

   // A hardwired register 0 swallows writes and is never a bypass source.
   assign w_hitZero = (ZERO_R0 != 0) && (bus.WA == '0);
   assign w_writeOk = bus.EI && !reset && !w_hitZero;
   assign w_bypassA = (BYPASS != 0) && w_writeOk && (bus.RA == bus.WA);
   assign w_bypassB = (BYPASS != 0) && w_writeOk && (bus.RB == bus.WA);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
         r_valid    <= '0;
         r_valid[0] <= (ZERO_R0 != 0);
         r_wcount   <= (ZERO_R0 != 0) ? ONE : '0;
      end else if (w_writeOk) begin
         r_mem[bus.WA]   <= bus.D;
         r_valid[bus.WA] <= 1'b1;
         if (!r_valid[bus.WA]) begin
            r_wcount <= r_wcount + ONE;
         end
      end
   end

   assign bus.QA     = w_bypassA ? bus.D : r_mem[bus.RA];
   assign bus.QB     = w_bypassB ? bus.D : r_mem[bus.RB];
   assign bus.VA     = w_bypassA | r_valid[bus.RA];
   assign bus.VB     = w_bypassB | r_valid[bus.RB];
   assign bus.valid  = r_valid;
   assign bus.wcount = r_wcount;
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Parametrised multi-register storage: the successor to the single-width enable-gated register in the CPU datapath. It holds NREGS registers of WIDTH bits, with one synchronous write port, two combinational read ports and per-register valid tracking. All state is clocked directly by clk; the write enable EI is a synchronous enable and never gates the clock. It serves the CPU as its general-purpose register file (operand A/B reads, ALU result writeback).

Parameters:
WIDTH, 8, data bits per register (1..32)
NREGS, 4, number of registers (power of 2, 2..16)
AW, log2(NREGS), address width (derived; not overridden)
ZERO_R0, 0, 1 = register 0 is hardwired to zero, ignores writes and is always valid
BYPASS, 1, 1 = a read of the address being written this cycle returns D (write-through); 0 = returns the stored value

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
EI  input  1  write enable, sampled on rising clk
WA  input  AW  write address
D  input  WIDTH  write data
RA  input  AW  read address, port A
RB  input  AW  read address, port B
QA  output  WIDTH  read data, port A (combinational from RA/state)
QB  output  WIDTH  read data, port B
VA  output  1  valid flag of register RA (written since reset)
VB  output  1  valid flag of register RB
valid  output  NREGS  per-register valid vector, bit i = register i
wcount  output  AW+1  number of valid registers (0..NREGS)

Behaviour:
- Reset: at a rising clk with reset=1, all registers become 0 and all valid bits become 0, except valid[0]=1 when ZERO_R0=1. After reset: QA=QB=0, wcount=0 (1 if ZERO_R0=1).
- reset has priority over EI: a write in the reset cycle is discarded.
- Write: at a rising clk with reset=0 and EI=1, reg[WA] <= D and valid[WA] <= 1. With EI=0 all state holds; D and WA are don't-care.
- ZERO_R0=1 and WA=0: the write is ignored, reg[0] stays 0 and valid[0] stays 1. Bypass does not apply to address 0.
- Read latency is 0: QA=reg[RA] and QB=reg[RB] combinationally. A write becomes visible through the stored value after the clock edge.
- BYPASS=1: if EI=1, reset=0 and RA==WA (and WA!=0 when ZERO_R0=1), then QA=D and VA=1 in the same cycle. The same rule applies to port B.
- BYPASS=0: reads return pre-edge contents, so read-during-write yields the old value.
- Both read ports may address the same register, including the write address; both return identical data.
- VA/VB follow the same bypass rule as QA/QB.
- wcount is a registered counter:
  - increments by 1 on a write to a register whose valid bit was 0;
  - unchanged when rewriting an already-valid register;
  - never exceeds NREGS;
  - must always equal the popcount of valid (verification invariant).
- Reset mid-operation: state returns to its reset values on that edge, whatever EI/WA/D are. Outputs then reflect reset contents, with bypass suppressed while reset=1.
- No X propagation: outputs are defined whenever inputs are known.

Test Plan:
- Reset then read: reset=1 for 1 cycle, then RA=0..3 -> QA=0, VA=0, valid=4'b0000, wcount=0 (defaults).
- Write and readback: EI=1, WA=2, D=8'hA5; next cycle RA=2, RB=2 -> QA=QB=8'hA5, VA=1, valid=4'b0100, wcount=1; rewrite WA=2, D=8'h3C -> wcount stays 1.
- Bypass: BYPASS=1, EI=1, WA=RA=1, D=8'h77 with reg1=0 -> QA=8'h77 in the same cycle. The same stimulus with BYPASS=0 -> QA=0 in the cycle, 8'h77 after the edge.
- Enable hold: EI=0, WA=3, D=8'hFF for 3 cycles -> reg3 unchanged (0), valid[3]=0.
- ZERO_R0=1: write WA=0, D=8'h55 -> QA(RA=0)=0, valid[0]=1, wcount unchanged; write all regs 1..3 -> wcount=4.
- Reset priority: EI=1, WA=1, D=8'h12 with reset=1 on the same edge -> reg1=0, valid[1]=0, wcount=0. Fill all regs, then pulse reset -> all QA=0, wcount=0.
